// File: rtl/keyexp_pkg.sv
// Shared constants, types and byte-level helpers for the AES-128 key expansion controller.
package keyexp_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned NUM_SLOTS  = 11;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } kx_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_expansion_ctrl_core.sv
// keyScheduleCore: RotWord, SubWord and round-constant XOR applied to the last word of a round key.
module keyScheduleCore
  import keyexp_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [3:0]  rnd_i,
  output logic [31:0] t_o
);

  logic [31:0] rot;
  logic [31:0] sub;

  always_comb begin
    rot = {word_i[23:0], word_i[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t_o = sub ^ {rcon(rnd_i), 24'h000000};
  end

endmodule

// File: rtl/key_expansion_ctrl.sv
// AES-128 key expansion controller with 11-slot round-key store.
// Define KEYEXP_WORD_SERIAL_EN to build one word per cycle (40-cycle expansion) instead of one round per cycle.
module key_expansion_ctrl
  import keyexp_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         key_ready
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  kx_state_e  state_q;
  logic [3:0] rnd_q;
  logic       busy_q;
  logic       ready_q;
  round_key_t slot_q [NUM_SLOTS];

  logic [3:0]  rnd_core;
  round_key_t  prev_rk;
  round_key_t  next_rk;
  logic [31:0] core_t;
  logic [3:0]  rd_idx;

`ifdef KEYEXP_WORD_SERIAL_EN
  logic [1:0] wsel_q;
  round_key_t cur_rk;
`endif

  // rnd is only 0 in IDLE; clamp so the rcon lookup and slot read always see 1..10.
  always_comb begin
    rnd_core = ((rnd_q >= 4'd1) && (rnd_q <= LAST_RND)) ? rnd_q : 4'd1;
    prev_rk  = slot_q[rnd_core - 4'd1];
  end

  keyScheduleCore u_core (
    .word_i (prev_rk[31:0]),
    .rnd_i  (rnd_core),
    .t_o    (core_t)
  );

`ifdef KEYEXP_WORD_SERIAL_EN
  // Each word chains off the word written into the same slot on the previous cycle.
  always_comb begin
    cur_rk  = slot_q[rnd_core];
    next_rk = cur_rk;
    case (wsel_q)
      2'd0: next_rk[127:96] = prev_rk[127:96] ^ core_t;
      2'd1: next_rk[95:64]  = prev_rk[95:64]  ^ cur_rk[127:96];
      2'd2: next_rk[63:32]  = prev_rk[63:32]  ^ cur_rk[95:64];
      default: next_rk[31:0] = prev_rk[31:0]  ^ cur_rk[63:32];
    endcase
  end
`else
  always_comb begin
    next_rk[127:96] = prev_rk[127:96] ^ core_t;
    next_rk[95:64]  = prev_rk[95:64]  ^ next_rk[127:96];
    next_rk[63:32]  = prev_rk[63:32]  ^ next_rk[95:64];
    next_rk[31:0]   = prev_rk[31:0]   ^ next_rk[63:32];
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
`ifdef KEYEXP_WORD_SERIAL_EN
      wsel_q  <= '0;
`endif
    end else if (key_load) begin
      slot_q[0] <= key_in;
      rnd_q     <= 4'd1;
      state_q   <= EXPAND;
      busy_q    <= 1'b1;
      ready_q   <= 1'b0;
`ifdef KEYEXP_WORD_SERIAL_EN
      wsel_q    <= '0;
`endif
    end else begin
      case (state_q)
        EXPAND: begin
          slot_q[rnd_core] <= next_rk;
`ifdef KEYEXP_WORD_SERIAL_EN
          wsel_q <= wsel_q + 2'd1;
          if (wsel_q == 2'd3) begin
`else
          begin
`endif
            if (rnd_q == LAST_RND) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              rnd_q <= rnd_q + 4'd1;
            end
          end
        end
        IDLE, DONE: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_idx    = (rk_index <= LAST_RND) ? rk_index : 4'd0;
  assign round_key = (ready_q && (rk_index <= LAST_RND)) ? slot_q[rd_idx] : '0;
  assign busy      = busy_q;
  assign key_ready = ready_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Self-checking bench for key_expansion_ctrl against a word-array AES-128 key schedule model.
`timescale 1ns/1ps
module tb_key_expansion_ctrl;

`ifdef KEYEXP_WORD_SERIAL_EN
  localparam int LAT = 40;
`else
  localparam int LAT = 10;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk;
  logic         n_rst;
  logic         key_load;
  logic [127:0] key_in;
  logic [3:0]   rk_index;
  logic [127:0] round_key;
  logic         busy;
  logic         key_ready;

  int checks;
  int failures;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [11];

  key_expansion_ctrl dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .rk_index  (rk_index),
    .round_key (round_key),
    .busy      (busy),
    .key_ready (key_ready)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Pulses key_load for one edge; returns 1ns after that edge.
  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; key_load = 1'b0; key_in = '0; rk_index = 4'd0;
    #5;
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b ready=%b expected 0/0", busy, key_ready);
    end
    for (int i = 0; i < 11; i += 5) begin
      rk_index = 4'(i); #1;
      checks++;
      if (round_key !== '0) begin
        failures++;
        $display("FAIL reset_rk idx=%0d got=%h expected 0", i, round_key);
      end
    end
    #20 n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    int bad;
    model_expand(FIPS_KEY);
    load_key(FIPS_KEY);
    bad = 0;
    rk_index = 4'd5;
    for (int c = 0; c < LAT; c++) begin
      if (busy !== 1'b1 || key_ready !== 1'b0 || round_key !== '0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0 || busy !== 1'b0 || key_ready !== 1'b1) begin
      failures++;
      $display("FAIL fips_latency bad_cycles=%0d busy=%b ready=%b expected ready after %0d", bad, busy, key_ready, LAT);
    end
    rk_index = 4'd0; #1;
    checks++;
    if (round_key !== FIPS_KEY) begin
      failures++; $display("FAIL fips_rk0 got=%h expected %h", round_key, FIPS_KEY);
    end
    rk_index = 4'd1; #1;
    checks++;
    if (round_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      failures++; $display("FAIL fips_rk1 got=%h expected a0fafe1788542cb123a339392a6c7605", round_key);
    end
    rk_index = 4'd10; #1;
    checks++;
    if (round_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      failures++; $display("FAIL fips_rk10 got=%h expected d014f9a8c9ee2589e13f0cc8b6630ca6", round_key);
    end
    for (int i = 0; i < 16; i++) begin
      rk_index = 4'(i); #1;
      checks++;
      if (round_key !== ((i <= 10) ? exp_rk[i] : 128'h0)) begin
        failures++;
        $display("FAIL fips_model idx=%0d got=%h expected %h", i, round_key, (i <= 10) ? exp_rk[i] : 128'h0);
      end
    end
  endtask

  task automatic test_zero_key();
    load_key('0);
    for (int c = 0; c < LAT; c++) begin @(posedge clk); #1; end
    rk_index = 4'd1; #1;
    checks++;
    if (key_ready !== 1'b1 || round_key !== 128'h62636363626363636263636362636363) begin
      failures++;
      $display("FAIL zero_rk1 ready=%b got=%h expected 62636363626363636263636362636363", key_ready, round_key);
    end
  endtask

  task automatic test_abort();
    int bad;
    load_key(FIPS_KEY);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (busy !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    load_key('0);
    model_expand('0);
    rk_index = 4'd5;
    for (int c = 0; c < LAT; c++) begin
      if (busy !== 1'b1 || key_ready !== 1'b0 || round_key !== '0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0 || key_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_latency bad_cycles=%0d busy=%b ready=%b expected ready %0d after reload", bad, busy, key_ready, LAT);
    end
    rk_index = 4'd10; #1;
    checks++;
    if (round_key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e || round_key !== exp_rk[10]) begin
      failures++;
      $display("FAIL abort_rk10 got=%h expected b4ef5bcb3e92e21123e951cf6f8f188e", round_key);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k);
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
    #6 n_rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_flags busy=%b ready=%b expected 0/0", busy, key_ready);
    end
    #5 n_rst = 1'b1;
    bad = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(posedge clk); #1;
      rk_index = 4'(c % 11);
      #1;
      if (busy !== 1'b0 || key_ready !== 1'b0 || round_key !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midrst_idle bad_cycles=%0d expected 0", bad);
    end
    model_expand(k);
    load_key(k);
    for (int c = 0; c < LAT; c++) begin @(posedge clk); #1; end
    rk_index = 4'd0; #1;
    checks++;
    if (key_ready !== 1'b1 || round_key !== k) begin
      failures++;
      $display("FAIL midrst_reload ready=%b got=%h expected %h", key_ready, round_key, k);
    end
  endtask

  task automatic test_repeat_load();
    int bad;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    load_key(k);
    for (int c = 0; c < LAT; c++) begin @(posedge clk); #1; end
    load_key(k);
    bad = 0;
    rk_index = 4'd5;
    for (int c = 0; c < LAT; c++) begin
      if (busy !== 1'b1 || key_ready !== 1'b0 || round_key !== '0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0 || key_ready !== 1'b1) begin
      failures++;
      $display("FAIL repeat_latency bad_cycles=%0d ready=%b expected ready after %0d", bad, key_ready, LAT);
    end
    for (int i = 0; i < 11; i++) begin
      rk_index = 4'(i); #1;
      checks++;
      if (round_key !== exp_rk[i]) begin
        failures++;
        $display("FAIL repeat_rk idx=%0d got=%h expected %h", i, round_key, exp_rk[i]);
      end
    end
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    int idx;
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      load_key(k);
      for (int c = 0; c < LAT; c++) begin @(posedge clk); #1; end
      for (int j = 0; j < 12; j++) begin
        idx = (j < 11) ? j : int'($urandom_range(11, 15));
        rk_index = 4'(idx); #1;
        checks++;
        if (round_key !== ((idx <= 10) ? exp_rk[idx] : 128'h0)) begin
          failures++;
          $display("FAIL random_rk key=%0d idx=%0d got=%h expected %h", n, idx, round_key,
                   (idx <= 10) ? exp_rk[idx] : 128'h0);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    init_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_abort();
    test_reset_mid();
    test_repeat_load();
    test_random_keys();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_expansion_ctrl.md
KEY_EXPANSION_CTRL -- requirements
Module: key_expansion_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port key_load, input, 1 bit: a one-cycle pulse that starts expansion of key_in.
REQ-004 SHALL have port key_in, input, 128 bits: the cipher key, captured on a key_load cycle; bits [127:96] are word w0.
REQ-005 SHALL have port rk_index, input, 4 bits: the round-key read index, 0..10.
REQ-006 SHALL have port round_key, output, 128 bits: the stored round key at rk_index.
REQ-007 SHALL have port busy, output, 1 bit: high while expansion is in progress.
REQ-008 SHALL have port key_ready, output, 1 bit: high when all 11 round keys are valid.

Function
REQ-009 SHALL implement FSM states IDLE, EXPAND and DONE:
- IDLE to EXPAND on key_load.
- EXPAND to DONE after the final round.
- DONE to EXPAND on key_load.
REQ-010 SHALL, on a key_load cycle, write key_in to slot 0, set round counter rnd=1, enter EXPAND, and drop key_ready on the next edge.
REQ-011 SHALL, in EXPAND (default build), compute one round per cycle:
- t = core(prev[31:0], rnd), where core = rotate-left one byte, then S-box, then XOR rcon(rnd) into the top byte.
- w4 = w0^t, w5 = w4^w1, w6 = w5^w2, w7 = w6^w3.
- Write {w4,w5,w6,w7} to slot rnd, then increment rnd.
REQ-012 SHALL, in the default build, make key_ready rise exactly 10 cycles after the key_load edge (after the edge that writes slot 10), with busy high for those 10 cycles.
REQ-013 SHALL, on key_load asserted in EXPAND, abort and restart from the new key_in; the old expansion does not complete.
REQ-014 SHALL drive round_key combinationally from storage slot rk_index when key_ready=1 and rk_index<=10, and drive all-zeros otherwise.
REQ-015 SHALL hold all round keys stable in DONE until the next key_load.
REQ-016 SHALL keep busy and key_ready mutually exclusive, and keep both low in IDLE.
REQ-017 SHALL never drive rnd outside 1..10 into the rcon lookup; rnd is frozen in IDLE and DONE.

Reset
REQ-018 SHALL, on n_rst=0 and independent of clk, force:
- state to IDLE, rnd to 0, busy to 0, key_ready to 0;
- all 11 storage slots to zero, so round_key reads 0.
REQ-019 SHALL, when reset asserts mid-EXPAND, discard the partial expansion; a key_load is required after reset release.

Configuration
REQ-020 SHALL use macro KEYEXP_WORD_SERIAL_EN.
- Defined: one 32-bit word per cycle, 4 cycles per round; core is applied only on the first word of each round, and words 5-7 use plain XOR.
- Defined: key_ready rises 40 cycles after key_load, with the same abort and reset rules.
- Undefined: the one-round-per-cycle behaviour of REQ-011/REQ-012 applies.

Structure
REQ-021 SHALL take constants from the shared package keyexp_pkg:
- NUM_ROUNDS=10, NUM_SLOTS=11, the state enum type, and the 128-bit round-key typedef.
REQ-022 SHALL instantiate exactly one keyScheduleCore as its sub-module, fed by prev[31:0] and rnd.
- Storage, sequencing and XOR chain stay in this module.

Verification
REQ-023 SHALL drive key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c.
- key_ready rises 10 cycles later (40 with KEYEXP_WORD_SERIAL_EN).
- rk_index=0 returns the key unchanged.
- rk_index=1 returns a0fafe1788542cb123a339392a6c7605.
- rk_index=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-024 SHALL check key_in=0, rk_index=1: round_key=62636363626363636263636362636363.
REQ-025 SHALL check a key_load of the all-zero key at cycle 4 of an expansion of the FIPS key.
- busy stays high and key_ready rises 10 cycles after the second load.
- rk_index=10 returns b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-026 SHALL check rk_index=11..15 while key_ready=1: round_key=0; rk_index=5 while busy=1: round_key=0.
REQ-027 SHALL check n_rst pulsed low mid-EXPAND, asynchronous to clk.
- busy and key_ready are 0 immediately.
- round_key stays 0 until a new key_load completes.
REQ-028 SHALL check a repeated key_load in DONE with the same key: key_ready drops for 10 cycles, then the same round keys return.
